// File: rtl/keypad_scan_ctrl.sv
// Column-scan controller for a 4x4 keypad: walks one active-low column per dwell,
// debounces press and release on the sampled row, and reports the accepted key.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       col_idx_r, col_idx_s;
    logic [1:0]       cand_r, cand_s;
    logic [CNT_W-1:0] db_cnt_r, db_cnt_s;
    logic [CNT_W-1:0] db_inc_s;
    logic [3:0]       col_n_r;
    logic [3:0]       key_code_r, key_code_s;
    logic             key_valid_r, key_valid_s;
    logic             key_held_r, key_held_s;
    logic             tick_s;
    logic             cand_level_s;

    // Simultaneous presses resolve to the lowest-indexed low row.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    assign tick_s       = (div_cnt_r == DIV_LAST);
    assign cand_level_s = row_n[cand_r];
    assign db_inc_s     = db_cnt_r + CNT_W'(1);

    // Scan timebase: one tick at the end of every column dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= '0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Next-state and output decode; everything holds except on tick cycles.
    always_comb begin
        state_s     = state_r;
        col_idx_s   = col_idx_r;
        cand_s      = cand_r;
        db_cnt_s    = db_cnt_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;
        if (tick_s) begin
            case (state_r)
                ST_SCAN: begin
                    if (row_n == 4'b1111) begin
                        col_idx_s = col_idx_r + 2'd1;
                    end else begin
                        cand_s   = lowest_low(row_n);
                        db_cnt_s = CNT_W'(1);
                        state_s  = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cand_level_s) begin
                        db_cnt_s = db_inc_s;
                        if (db_inc_s == DB_LAST) begin
                            key_code_s  = {cand_r, col_idx_r};
                            key_valid_s = 1'b1;
                            key_held_s  = 1'b1;
                            state_s     = ST_HOLD;
                        end else begin
                            state_s = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_s = col_idx_r + 2'd1;
                        state_s   = ST_SCAN;
                    end
                end
                ST_HOLD: begin
                    if (cand_level_s) begin
                        db_cnt_s = CNT_W'(1);
                        state_s  = ST_RELEASE;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_RELEASE: begin
                    if (cand_level_s) begin
                        db_cnt_s = db_inc_s;
                        if (db_inc_s == DB_LAST) begin
                            key_held_s = 1'b0;
                            col_idx_s  = col_idx_r + 2'd1;
                            state_s    = ST_SCAN;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_SCAN;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs; col_n is decoded from the next column index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_SCAN;
            col_idx_r   <= 2'd0;
            cand_r      <= 2'd0;
            db_cnt_r    <= '0;
            col_n_r     <= 4'b1110;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            col_idx_r   <= col_idx_s;
            cand_r      <= cand_s;
            db_cnt_r    <= db_cnt_s;
            col_n_r     <= ~(4'b0001 << col_idx_s);
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
        end
    end

    assign col_n     = col_n_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Column-scan controller for the 4x4 keypad.
- Drives one column low at a time and samples the registered, active-low row lines coming out of the row sampling flip-flops.
- Debounces presses and releases, then emits a 4-bit key code with a one-cycle valid strobe to the downstream display/consumer logic.
- Provides the scan timebase, so no separate slow clock is required.

Parameters:
- SCAN_DIV, 50000, clk cycles per column dwell (one "tick" per dwell); minimum 2.
- DEBOUNCE_TICKS, 4, consecutive identical row samples required to accept a press or a release; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- row_n  input  4  registered row levels, active-low (0 = row pulled low by pressed key).
- col_n  output  4  column drive, active-low one-cold; bit i low selects column i.
- key_code  output  4  last accepted key = row_idx*4 + col_idx.
- key_valid  output  1  one-cycle strobe when a debounced press is accepted.
- key_held  output  1  high while the accepted key is considered pressed.

Behaviour:
- Reset values (the cycle after rst is sampled high):
  - tick counter 0, col_idx 0, so col_n = 4'b1110.
  - state SCAN.
  - key_code 0, key_valid 0, key_held 0.
  - debounce count 0, candidate row 0.
- Reset mid-operation: any state returns to the values above on the next edge. No key_valid is emitted.
- Tick generation:
  - Counter runs 0..SCAN_DIV-1 and wraps to 0.
  - tick = 1 in the cycle where the counter equals SCAN_DIV-1.
  - All row sampling and state decisions occur only on tick cycles.
- col_n = ~(4'b0001 << col_idx). col_idx changes only on tick, and only where stated below (wrap 3 -> 0).
- State SCAN:
  - On tick, if row_n == 4'b1111: col_idx advances.
  - On tick, if any row_n bit is 0: latch candidate row = lowest-indexed low bit, set debounce count = 1, go to DEBOUNCE.
  - col_idx is frozen while in DEBOUNCE.
- State DEBOUNCE:
  - On tick, if row_n[candidate] == 0: count increments.
  - When count reaches DEBOUNCE_TICKS:
    - key_code <= candidate*4 + col_idx.
    - key_valid = 1 for exactly one clk.
    - key_held <= 1.
    - go to HOLD.
  - On tick, if row_n[candidate] == 1: abandon the candidate (no key_valid), col_idx advances, go to SCAN.
  - Other row bits are ignored in this state.
- State HOLD:
  - Column stays frozen.
  - On tick, if row_n[candidate] == 1: count = 1, go to RELEASE.
  - Otherwise stay in HOLD.
  - No repeat strobes.
- State RELEASE:
  - On tick, if row_n[candidate] == 1: count increments.
  - When count reaches DEBOUNCE_TICKS: key_held <= 0, col_idx advances, go to SCAN.
  - On tick, if row_n[candidate] == 0 (bounce): go back to HOLD. key_held stays 1 and no new key_valid is emitted.
- Latency: key_valid rises in the cycle after the tick carrying the DEBOUNCE_TICKS-th consecutive low sample. The first low sample (taken in SCAN) counts as sample 1.
- Simultaneous presses: lowest row index in the current column wins. Other keys are ignored until release completes.
- key_code holds its value after release until the next accepted press.
- key_valid and key_held update on the same edge at acceptance.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_TICKS=3, rst pulse, row_n=1111 -> col_n=1110 after reset. Sequence 1110, 1101, 1011, 0111, 1110, changing every 4 clks. key_valid stays 0.
- Hold row_n[2]=0 only while col_n=1101, for 3+ ticks -> col freezes at 1101. key_code=9, single-cycle key_valid 1 clk after the 3rd low sample, key_held=1.
- Keep the key pressed for 20 ticks -> no further key_valid. key_held stays 1. col_n stays 1101.
- Release with one-tick bounce (high, low, high, high, high) -> key_held stays 1 through the bounce and drops after 3 consecutive high samples. col_n then advances to 1011. key_code stays 9.
- Single low sample on row 1 at col 0 followed by high -> no key_valid. Scan resumes at col_n=1101.
- Rows 1 and 3 low together at col 3 -> key_code=7 (row 1). Separately, assert rst while in HOLD -> next cycle col_n=1110, key_held=0, key_code=0, key_valid=0.
